// File: rtl/fft_peak_bin_tracker_pkg.sv
// fft_pkg: shared constants and types for the FFT peak-bin tracker.
// Optional feature macro used by the tracker: FFT_FRAME_CHECK_EN.
package fft_pkg;

  localparam int FFT_LEN = 1024;
  localparam int BIN_W   = $clog2(FFT_LEN);
  localparam int MIN_BIN = 2;              // skip DC / near-DC bins
  localparam int MAX_BIN = FFT_LEN/2 - 1;  // mirror half of a real FFT is ignored

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } fft_sample_t;

  typedef logic [31:0]      mag_t;
  typedef logic [BIN_W-1:0] bin_t;

  // True when a bin lies inside the band that may carry the peak.
  function automatic logic bin_eligible(input bin_t b);
    return (b >= BIN_W'(MIN_BIN)) && (b <= BIN_W'(MAX_BIN));
  endfunction

endpackage

// File: rtl/fft_peak_bin_tracker_if.sv
// AXI-Stream style bin stream from the FFT core into the peak tracker.
interface fft_peak_bin_tracker_if;
  import fft_pkg::*;

  fft_sample_t fft_data_in;
  logic        fft_valid_in;
  logic        fft_last_in;
  logic        fft_ready_out;

  modport master (output fft_data_in, fft_valid_in, fft_last_in, input fft_ready_out);
  modport slave  (input fft_data_in, fft_valid_in, fft_last_in, output fft_ready_out);

endinterface

// File: rtl/fft_peak_bin_tracker_cplx_mag_sq.sv
// cplx_mag_sq: two-stage pipelined |x|^2 = re^2 + im^2 with valid/last/bin passthrough.
module cplx_mag_sq
  import fft_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  fft_sample_t sample_i,
  input  logic        valid_i,
  input  logic        last_i,
  input  bin_t        bin_i,
  output mag_t        mag_o,
  output logic        valid_o,
  output logic        last_o,
  output bin_t        bin_o
);

  // Operands widened first so each square is formed at its full 31-bit width.
  logic signed [30:0] re_x, im_x;
  logic        [30:0] re_sq_d, im_sq_d, re_sq_q, im_sq_q;
  logic               s1_valid_q, s1_last_q;
  bin_t               s1_bin_q;
  mag_t               mag_d, mag_q;
  logic               s2_valid_q, s2_last_q;
  bin_t               s2_bin_q;

  assign re_x    = 31'(sample_i.re);
  assign im_x    = 31'(sample_i.im);
  assign re_sq_d = re_x * re_x;  // max (-32768)^2 = 2^30
  assign im_sq_d = im_x * im_x;
  assign mag_d   = {1'b0, re_sq_q} + {1'b0, im_sq_q};  // max 2^31, no overflow

  // Valid bits: the only pipeline state that must be cleared by reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= valid_i;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Datapath and sideband capture for both stages.
  always_ff @(posedge clk_in) begin
    // NOTE: datapath registers carry no reset; the valid bits qualify them.
    re_sq_q   <= re_sq_d;
    im_sq_q   <= im_sq_d;
    s1_last_q <= last_i;
    s1_bin_q  <= bin_i;
    mag_q     <= mag_d;
    s2_last_q <= s1_last_q;
    s2_bin_q  <= s1_bin_q;
  end

  assign mag_o   = mag_q;
  assign valid_o = s2_valid_q;
  assign last_o  = s2_last_q;
  assign bin_o   = s2_bin_q;

endmodule

// File: rtl/fft_peak_bin_tracker.sv
// fft_peak_bin_tracker: per-frame strongest-bin finder on the FFT output stream.
// Optional macro FFT_FRAME_CHECK_EN adds frame_err_out and force-closes a frame
// at bin FFT_LEN-1 when tlast is missing.
module fft_peak_bin_tracker
  import fft_pkg::*;
(
  input  logic                         clk_in,
  input  logic                         rst_in,
  fft_peak_bin_tracker_if.slave        fft_if,
  output bin_t                         peak_bin_out,
  output mag_t                         peak_mag_out,
  output logic                         peak_valid_out
`ifdef FFT_FRAME_CHECK_EN
  ,
  output logic                         frame_err_out
`endif
);

  logic ready_q;
  logic accept, cnt_at_end;
  bin_t bin_cnt_q, bin_cnt_d;

  mag_t s2_mag;
  logic s2_valid, s2_last;
  bin_t s2_bin;
  logic close, take;

  bin_t max_bin_q, max_bin_d, peak_bin_q, peak_bin_d;
  mag_t max_mag_q, max_mag_d, peak_mag_q, peak_mag_d;
  logic found_q, found_d, peak_valid_q, peak_valid_d;

  assign accept     = fft_if.fft_valid_in && ready_q;
  assign cnt_at_end = (bin_cnt_q == BIN_W'(FFT_LEN-1));

  // Ready comes up the first cycle after reset and never drops.
  always_ff @(posedge clk_in) begin
    if (rst_in) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Bin index of the next accepted beat; restarts after tlast or at FFT_LEN-1.
  always_comb begin
    // NOTE: default first, so every path assigns and no latch is inferred.
    bin_cnt_d = bin_cnt_q;
    if (accept) bin_cnt_d = (fft_if.fft_last_in || cnt_at_end) ? '0 : bin_cnt_q + BIN_W'(1);
  end

  cplx_mag_sq u_mag (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sample_i (fft_if.fft_data_in),
    .valid_i  (accept),
    .last_i   (fft_if.fft_last_in),
    .bin_i    (bin_cnt_q),
    .mag_o    (s2_mag),
    .valid_o  (s2_valid),
    .last_o   (s2_last),
    .bin_o    (s2_bin)
  );

`ifdef FFT_FRAME_CHECK_EN
  logic s2_at_end, frame_err_d, frame_err_q;
  assign s2_at_end   = (s2_bin == BIN_W'(FFT_LEN-1));
  assign close       = s2_valid && (s2_last || s2_at_end);
  // Error when tlast and the final bin disagree: early tlast or missing tlast.
  assign frame_err_d = s2_valid && (s2_last ^ s2_at_end);
`else
  assign close = s2_valid && s2_last;
`endif

  // First eligible bin loads unconditionally; later ones only if strictly larger.
  assign take = s2_valid && bin_eligible(s2_bin) && (!found_q || (s2_mag > max_mag_q));

  // Running-max update and frame close; the max clears on the closing beat.
  always_comb begin
    max_bin_d    = max_bin_q;
    max_mag_d    = max_mag_q;
    found_d      = found_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_valid_d = 1'b0;
    if (close) begin
      // Running max sits at 0/0 when no eligible bin was seen.
      peak_bin_d   = take ? s2_bin : max_bin_q;
      peak_mag_d   = take ? s2_mag : max_mag_q;
      peak_valid_d = 1'b1;
      max_bin_d    = '0;
      max_mag_d    = '0;
      found_d      = 1'b0;
    end else if (take) begin
      max_bin_d = s2_bin;
      max_mag_d = s2_mag;
      found_d   = 1'b1;
    end
  end

  // Counter, running max and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bin_cnt_q    <= '0;
      max_bin_q    <= '0;
      max_mag_q    <= '0;
      found_q      <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      bin_cnt_q    <= bin_cnt_d;
      max_bin_q    <= max_bin_d;
      max_mag_q    <= max_mag_d;
      found_q      <= found_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_valid_q <= peak_valid_d;
    end
  end

`ifdef FFT_FRAME_CHECK_EN
  // Frame-length error pulse, aligned with peak_valid_out.
  always_ff @(posedge clk_in) begin
    if (rst_in) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end
  assign frame_err_out = frame_err_q;
`endif

  assign fft_if.fft_ready_out = ready_q;
  assign peak_bin_out         = peak_bin_q;
  assign peak_mag_out         = peak_mag_q;
  assign peak_valid_out       = peak_valid_q;

endmodule

// File: tb/tb_fft_peak_bin_tracker.sv
// Self-checking bench for fft_peak_bin_tracker (also covers FFT_FRAME_CHECK_EN when defined).
`timescale 1ns/1ps
module tb_fft_peak_bin_tracker;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_peak_bin_tracker_if bus();
  bin_t peak_bin;
  mag_t peak_mag;
  logic peak_valid;
`ifdef FFT_FRAME_CHECK_EN
  logic frame_err;
`endif

  fft_peak_bin_tracker dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .fft_if         (bus),
    .peak_bin_out   (peak_bin),
    .peak_mag_out   (peak_mag),
    .peak_valid_out (peak_valid)
`ifdef FFT_FRAME_CHECK_EN
    ,
    .frame_err_out  (frame_err)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int     bin;
    longint mag;
    int     cyc;
    bit     err;
  } exp_t;

  exp_t   exp_q[$];
  longint frame_q[$];   // magnitudes of the current frame, index = bin
  int     hold_bin = 0;
  longint hold_mag = 0;
  bit     in_rst   = 1'b1;

  // Called once per accepted beat; when the frame closes, the peak is the
  // largest magnitude in the band, and the lowest bin holding that value.
  task automatic model_accept(input logic signed [15:0] re, input logic signed [15:0] im,
                              input logic last, input int acc_cyc);
    bit     close, err;
    longint best;
    int     best_bin;
    exp_t   e;
    frame_q.push_back(longint'(re) * re + longint'(im) * im);
    close = last;
    err   = 1'b0;
`ifdef FFT_FRAME_CHECK_EN
    err   = (last != (frame_q.size() == FFT_LEN));
    close = last || (frame_q.size() == FFT_LEN);
`endif
    if (close) begin
      best     = 0;
      best_bin = 0;
      for (int i = MIN_BIN; i <= MAX_BIN && i < frame_q.size(); i++)
        if (frame_q[i] > best) best = frame_q[i];
      if (best > 0) begin
        for (int i = MAX_BIN < frame_q.size() - 1 ? MAX_BIN : frame_q.size() - 1; i >= MIN_BIN; i--)
          if (frame_q[i] == best) best_bin = i;
      end else if (frame_q.size() > MIN_BIN) begin
        best_bin = MIN_BIN;  // all eligible bins zero: first eligible bin wins with 0
      end
      e.bin = best_bin;
      e.mag = best;
      e.cyc = acc_cyc + 2;
      e.err = err;
      exp_q.push_back(e);
      frame_q.delete();
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!in_rst) begin
      check("ready", {31'd0, bus.fft_ready_out}, 32'd1);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("peak_valid", {31'd0, peak_valid}, 32'd1);
        check("peak_bin", {22'd0, peak_bin}, exp_q[0].bin);
        check("peak_mag", peak_mag, exp_q[0].mag[31:0]);
`ifdef FFT_FRAME_CHECK_EN
        check("frame_err", {31'd0, frame_err}, {31'd0, exp_q[0].err});
`endif
        hold_bin = exp_q[0].bin;
        hold_mag = exp_q[0].mag;
        void'(exp_q.pop_front());
      end else begin
        check("no_pulse", {31'd0, peak_valid}, 32'd0);
`ifdef FFT_FRAME_CHECK_EN
        check("no_err", {31'd0, frame_err}, 32'd0);
`endif
      end
      check("hold_bin", {22'd0, peak_bin}, hold_bin);
      check("hold_mag", peak_mag, hold_mag[31:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  int          pk_bin[$];
  logic [31:0] pk_val[$];

  task automatic pk_set(input int b, input logic signed [15:0] re, input logic signed [15:0] im);
    pk_bin.push_back(b);
    pk_val.push_back({re, im});
  endtask

  function automatic logic [31:0] pk_lookup(input int b);
    pk_lookup = '0;
    foreach (pk_bin[i]) if (pk_bin[i] == b) pk_lookup = pk_val[i];
  endfunction

  // One beat, accepted at the next rising edge (ready is high outside reset).
  task automatic beat(input logic [31:0] d, input logic last);
    bus.fft_data_in  = d;
    bus.fft_valid_in = 1'b1;
    bus.fft_last_in  = last;
    @(posedge clk);
    #1;
    model_accept(d[31:16], d[15:0], last, cyc);
    bus.fft_valid_in = 1'b0;
    bus.fft_last_in  = 1'b0;
    bus.fft_data_in  = 32'hDEAD_BEEF;  // junk while invalid must be ignored
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input bit last_en, input bit gaps);
    for (int b = 0; b < len; b++) begin
      if (gaps && b > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      beat(pk_lookup(b), last_en && (b == len - 1));
    end
    pk_bin.delete();
    pk_val.delete();
  endtask

  task automatic drain_and_pin(input string name, input int bin, input int mag);
    repeat (6) @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_bin"}, {22'd0, peak_bin}, bin);
    check({name, "_mag"}, peak_mag, mag);
  endtask

  task automatic do_reset(input int n);
    in_rst = 1'b1;
    rst    = 1'b1;
    repeat (n) @(negedge clk);
    check("rst_ready", {31'd0, bus.fft_ready_out}, 32'd0);
    check("rst_bin", {22'd0, peak_bin}, 32'd0);
    check("rst_mag", peak_mag, 32'd0);
    check("rst_valid", {31'd0, peak_valid}, 32'd0);
`ifdef FFT_FRAME_CHECK_EN
    check("rst_err", {31'd0, frame_err}, 32'd0);
`endif
    rst = 1'b0;
    frame_q.delete();
    exp_q.delete();
    hold_bin = 0;
    hold_mag = 0;
    @(negedge clk);
    check("rel_ready", {31'd0, bus.fft_ready_out}, 32'd1);
    in_rst = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.fft_data_in  = '0;
    bus.fft_valid_in = 1'b0;
    bus.fft_last_in  = 1'b0;
    do_reset(3);

    // Single tone at bin 37.
    pk_set(37, 16'sd1000, -16'sd500);
    send_frame(1024, 1'b1, 1'b0);
    drain_and_pin("tone37", 37, 1250000);

    // DC and mirror bins are larger but ineligible.
    pk_set(0, 16'sd32767, 16'sd0);
    pk_set(600, -16'sd32768, -16'sd32768);
    pk_set(100, 16'sd10, 16'sd0);
    send_frame(1024, 1'b1, 1'b0);
    drain_and_pin("band", 100, 100);

    // Tie keeps the lower bin.
    pk_set(50, 16'sd300, 16'sd400);
    pk_set(80, 16'sd300, 16'sd400);
    send_frame(1024, 1'b1, 1'b0);
    drain_and_pin("tie", 50, 250000);

    // Back-to-back frames with random valid gaps inside each frame.
    pk_set(5, 16'sd100, 16'sd100);
    send_frame(300, 1'b1, 1'b1);
    pk_set(200, -16'sd7, 16'sd24);
    send_frame(300, 1'b1, 1'b1);
    drain_and_pin("b2b", 200, 625);

    // Upper band edge: 511 eligible, 512 not.
    pk_set(1, 16'sd50, 16'sd0);
    pk_set(511, 16'sd1, 16'sd0);
    pk_set(512, 16'sd100, 16'sd0);
    send_frame(600, 1'b1, 1'b0);
    drain_and_pin("max_edge", 511, 1);

    // Lower band edge: bin 2 eligible, bin 1 not.
    pk_set(1, 16'sd9, 16'sd9);
    pk_set(2, 16'sd2, 16'sd0);
    send_frame(4, 1'b1, 1'b0);
    drain_and_pin("min_edge", 2, 4);

    // Short frame with no eligible bin still pulses with 0/0.
    pk_set(0, 16'sd7, 16'sd7);
    pk_set(1, 16'sd3, 16'sd0);
    send_frame(2, 1'b1, 1'b0);
    drain_and_pin("empty", 0, 0);

    // Reset mid-frame, then a clean frame.
    pk_set(300, 16'sd5000, 16'sd0);
    send_frame(400, 1'b0, 1'b0);
    do_reset(2);
    pk_set(7, 16'sd0, 16'sd4);
    pk_set(9, 16'sd3, 16'sd4);
    send_frame(20, 1'b1, 1'b0);
    drain_and_pin("post_rst", 9, 25);

`ifdef FFT_FRAME_CHECK_EN
    // Early tlast at bin 511: error pulse with the peak.
    pk_set(100, 16'sd10, 16'sd0);
    send_frame(512, 1'b1, 1'b0);
    drain_and_pin("early_last", 100, 100);
    // Missing tlast: force-close at bin 1023, counter wraps.
    pk_set(3, 16'sd1, 16'sd1);
    send_frame(1024, 1'b0, 1'b0);
    drain_and_pin("no_last", 3, 2);
    pk_set(4, 16'sd2, 16'sd2);
    send_frame(1024, 1'b1, 1'b0);
    drain_and_pin("after_wrap", 4, 8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
